// File: rtl/hazard_detect_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, memory-wait freeze with watchdog.
// Optional perf counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_detect_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_RegisterRt,
    input  logic [4:0] IF_ID_RegisterRs,
    input  logic [4:0] IF_ID_RegisterRt,
    input  logic       IF_ID_UsesRt,
    input  logic       EX_MEM_Branch,
    input  logic       EX_MEM_Zero,
    input  logic       EX_MEM_MemRead,
    input  logic       EX_MEM_MemWrite,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_Flush_lwstall,
    output logic       ID_Flush_Branch,
    output logic       EX_Flush,
    output logic       Freeze,
    output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] lwstall_cnt,
    output logic [15:0] brflush_cnt,
    output logic [15:0] memwait_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LWS,
        ST_MWAIT
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic lu, br, mb;

    always_comb begin
        lu = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
             ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
              (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));
        br = EX_MEM_Branch && EX_MEM_Zero;
        mb = (EX_MEM_MemRead || EX_MEM_MemWrite) && !mem_ready;
    end

    always_comb begin
        PCWrite          = 1'b1;
        IF_ID_Write      = 1'b1;
        IF_ID_Flush      = 1'b0;
        ID_Flush_lwstall = 1'b0;
        ID_Flush_Branch  = 1'b0;
        EX_Flush         = 1'b0;
        Freeze           = 1'b0;
        state_d          = state_q;
        cnt_d            = cnt_q;
        mem_timeout_d    = mem_timeout_q;

        if (!reset) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            state_d       = ST_RUN;
            cnt_d         = '0;
            mem_timeout_d = 1'b0;
        end else begin
            // Output priority: memory freeze, then branch flush, then load-use stall.
            if (mb) begin
                Freeze      = 1'b1;
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
            end else if (br) begin
                IF_ID_Flush     = 1'b1;
                ID_Flush_Branch = 1'b1;
                EX_Flush        = 1'b1;
            end else if (lu && (state_q != ST_LWS)) begin
                ID_Flush_lwstall = 1'b1;
                PCWrite          = 1'b0;
                IF_ID_Write      = 1'b0;
            end

            case (state_q)
                ST_RUN: begin
                    if (mb)
                        state_d = ST_MWAIT;
                    else if (lu && !br)
                        state_d = ST_LWS;
                end
                ST_LWS: begin
                    state_d = mb ? ST_MWAIT : ST_RUN;
                end
                ST_MWAIT: begin
                    if (mem_ready) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        if (cnt_q != '1)
                            cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == TO_LAST)
                            mem_timeout_d = 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        cnt_q         <= cnt_d;
        mem_timeout_q <= mem_timeout_d;
    end

    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] lwstall_cnt_q, lwstall_cnt_d;
    logic [15:0] brflush_cnt_q, brflush_cnt_d;
    logic [15:0] memwait_cnt_q, memwait_cnt_d;

    always_comb begin
        lwstall_cnt_d = lwstall_cnt_q;
        brflush_cnt_d = brflush_cnt_q;
        memwait_cnt_d = memwait_cnt_q;
        if (!reset) begin
            lwstall_cnt_d = '0;
            brflush_cnt_d = '0;
            memwait_cnt_d = '0;
        end else begin
            if (ID_Flush_lwstall && (lwstall_cnt_q != '1))
                lwstall_cnt_d = lwstall_cnt_q + 16'd1;
            if (ID_Flush_Branch && (brflush_cnt_q != '1))
                brflush_cnt_d = brflush_cnt_q + 16'd1;
            if (Freeze && (memwait_cnt_q != '1))
                memwait_cnt_d = memwait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        lwstall_cnt_q <= lwstall_cnt_d;
        brflush_cnt_q <= brflush_cnt_d;
        memwait_cnt_q <= memwait_cnt_d;
    end

    assign lwstall_cnt = lwstall_cnt_q;
    assign brflush_cnt = brflush_cnt_q;
    assign memwait_cnt = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed self-checking bench for hazard_detect_unit (watchdog shortened to 3 cycles).
module tb_hazard_detect_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_RegisterRt;
    logic [4:0] IF_ID_RegisterRs;
    logic [4:0] IF_ID_RegisterRt;
    logic       IF_ID_UsesRt;
    logic       EX_MEM_Branch;
    logic       EX_MEM_Zero;
    logic       EX_MEM_MemRead;
    logic       EX_MEM_MemWrite;
    logic       mem_ready;
    logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_Flush_lwstall;
    logic       ID_Flush_Branch, EX_Flush, Freeze, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] lwstall_cnt, brflush_cnt, memwait_cnt;
`endif

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_Flush_lwstall, ID_Flush_Branch, EX_Flush, Freeze, mem_timeout}
    localparam logic [7:0] O_RST = 8'h00;
    localparam logic [7:0] O_DEF = 8'hC0;
    localparam logic [7:0] O_STL = 8'h10;
    localparam logic [7:0] O_BR  = 8'hEC;
    localparam logic [7:0] O_FRZ = 8'h02;

    logic [7:0] outs;
    assign outs = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_Flush_lwstall,
                   ID_Flush_Branch, EX_Flush, Freeze, mem_timeout};

    hazard_detect_unit #(.TIMEOUT_CYCLES(3), .CNT_W(8)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_RegisterRt (ID_EX_RegisterRt),
        .IF_ID_RegisterRs (IF_ID_RegisterRs),
        .IF_ID_RegisterRt (IF_ID_RegisterRt),
        .IF_ID_UsesRt     (IF_ID_UsesRt),
        .EX_MEM_Branch    (EX_MEM_Branch),
        .EX_MEM_Zero      (EX_MEM_Zero),
        .EX_MEM_MemRead   (EX_MEM_MemRead),
        .EX_MEM_MemWrite  (EX_MEM_MemWrite),
        .mem_ready        (mem_ready),
        .PCWrite          (PCWrite),
        .IF_ID_Write      (IF_ID_Write),
        .IF_ID_Flush      (IF_ID_Flush),
        .ID_Flush_lwstall (ID_Flush_lwstall),
        .ID_Flush_Branch  (ID_Flush_Branch),
        .EX_Flush         (EX_Flush),
        .Freeze           (Freeze),
        .mem_timeout      (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .lwstall_cnt      (lwstall_cnt),
        .brflush_cnt      (brflush_cnt),
        .memwait_cnt      (memwait_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then check the combinational outputs.
    task automatic vec(input string tag, input logic rstn,
                       input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                       input logic [4:0] irt, input logic uses,
                       input logic brn, input logic zero,
                       input logic mrd, input logic mwr, input logic rdy,
                       input logic [7:0] exp);
        @(negedge clk);
        reset            = rstn;
        ID_EX_MemRead    = mr;
        ID_EX_RegisterRt = rt;
        IF_ID_RegisterRs = rs;
        IF_ID_RegisterRt = irt;
        IF_ID_UsesRt     = uses;
        EX_MEM_Branch    = brn;
        EX_MEM_Zero      = zero;
        EX_MEM_MemRead   = mrd;
        EX_MEM_MemWrite  = mwr;
        mem_ready        = rdy;
        #1;
        check_eq(tag, {8'h00, outs}, {8'h00, exp});
    endtask

    initial begin
        reset = 1'b0;
        ID_EX_MemRead = 1'b0; ID_EX_RegisterRt = '0; IF_ID_RegisterRs = '0;
        IF_ID_RegisterRt = '0; IF_ID_UsesRt = 1'b0; EX_MEM_Branch = 1'b0;
        EX_MEM_Zero = 1'b0; EX_MEM_MemRead = 1'b0; EX_MEM_MemWrite = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);

        //   tag            rstn mr rt    rs    irt   use br z  mrd mwr rdy exp
        vec("rst_idle",     0,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 0,  0,  0,  O_RST);
        vec("rst_force",    0,   1, 5'd5, 5'd5, 5'd0, 0,  1, 1, 1,  0,  0,  O_RST);
        vec("idle",         1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 0,  0,  0,  O_DEF);
        vec("lu_rs",        1,   1, 5'd5, 5'd5, 5'd0, 0,  0, 0, 0,  0,  0,  O_STL);
        vec("lu_mask",      1,   1, 5'd5, 5'd5, 5'd0, 0,  0, 0, 0,  0,  0,  O_DEF);
        vec("lu_again",     1,   1, 5'd5, 5'd5, 5'd0, 0,  0, 0, 0,  0,  0,  O_STL);
        vec("idle2",        1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 0,  0,  0,  O_DEF);
        vec("rt_nouse",     1,   1, 5'd7, 5'd1, 5'd7, 0,  0, 0, 0,  0,  0,  O_DEF);
        vec("lu_rt",        1,   1, 5'd7, 5'd1, 5'd7, 1,  0, 0, 0,  0,  0,  O_STL);
        vec("idle3",        1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 0,  0,  0,  O_DEF);
        vec("reg0",         1,   1, 5'd0, 5'd0, 5'd0, 1,  0, 0, 0,  0,  0,  O_DEF);
        vec("br_lu",        1,   1, 5'd5, 5'd5, 5'd0, 0,  1, 1, 0,  0,  0,  O_BR);
        vec("lu_after_br",  1,   1, 5'd5, 5'd5, 5'd0, 0,  0, 0, 0,  0,  0,  O_STL);
        vec("idle4",        1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 0,  0,  0,  O_DEF);
        vec("br_not_taken", 1,   0, 5'd0, 5'd0, 5'd0, 0,  1, 0, 0,  0,  0,  O_DEF);
        vec("rdy_first",    1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 1,  0,  1,  O_DEF);
        vec("lu_no_mwait",  1,   1, 5'd5, 5'd5, 5'd0, 0,  0, 0, 0,  0,  0,  O_STL);
        vec("mb_in_lws",    1,   1, 5'd5, 5'd5, 5'd0, 0,  0, 0, 0,  1,  0,  O_FRZ);
        vec("mb_lu",        1,   1, 5'd5, 5'd5, 5'd0, 0,  0, 0, 0,  1,  0,  O_FRZ);
        vec("mw_release",   1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 0,  1,  1,  O_DEF);
        vec("lu_rerun",     1,   1, 5'd5, 5'd5, 5'd0, 0,  0, 0, 0,  0,  0,  O_STL);
        vec("idle5",        1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 0,  0,  0,  O_DEF);

        for (int i = 1; i <= 4; i++)
            vec($sformatf("wait%0d", i), 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, O_FRZ);
        vec("wait_to",      1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 1,  0,  0,  O_FRZ | 8'h01);
        vec("rel_to",       1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 1,  0,  1,  O_DEF | 8'h01);
        vec("to_sticky",    1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 0,  0,  0,  O_DEF | 8'h01);
        vec("lu_pre_rst",   1,   1, 5'd5, 5'd5, 5'd0, 0,  0, 0, 0,  0,  0,  O_STL | 8'h01);
        vec("rst_in_lws",   0,   1, 5'd5, 5'd5, 5'd0, 0,  0, 0, 0,  0,  0,  O_RST | 8'h01);
        vec("lu_post_rst",  1,   1, 5'd5, 5'd5, 5'd0, 0,  0, 0, 0,  0,  0,  O_STL);
        vec("idle6",        1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 0,  0,  0,  O_DEF);
        vec("mw_pre_rst",   1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 1,  0,  0,  O_FRZ);
        vec("rst_in_mw",    0,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 1,  0,  0,  O_RST);
        vec("mw_post_rst",  1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 1,  0,  0,  O_FRZ);
        vec("mw_post_rel",  1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 1,  0,  1,  O_DEF);

`ifdef HAZARD_PERF_CNT_EN
        vec("pc_rst",       0,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 0,  0,  0,  O_RST);
        vec("pc_lu1",       1,   1, 5'd5, 5'd5, 5'd0, 0,  0, 0, 0,  0,  0,  O_STL);
        vec("pc_idle1",     1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 0,  0,  0,  O_DEF);
        vec("pc_lu2",       1,   1, 5'd9, 5'd9, 5'd0, 0,  0, 0, 0,  0,  0,  O_STL);
        vec("pc_idle2",     1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 0,  0,  0,  O_DEF);
        vec("pc_br",        1,   0, 5'd0, 5'd0, 5'd0, 0,  1, 1, 0,  0,  0,  O_BR);
        for (int i = 1; i <= 3; i++)
            vec($sformatf("pc_wait%0d", i), 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, O_FRZ);
        vec("pc_rel",       1,   0, 5'd0, 5'd0, 5'd0, 0,  0, 0, 1,  0,  1,  O_DEF);
        @(negedge clk);
        check_eq("lwstall_cnt", lwstall_cnt, 16'd2);
        check_eq("brflush_cnt", brflush_cnt, 16'd1);
        check_eq("memwait_cnt", memwait_cnt, 16'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
